// File: rtl/s298_bist_pkg.sv
// Shared types and constants for the s298 BIST controller.
// Holds the FSM state encoding, the LFSR/MISR widths and feedback taps, and the CORE_OUT bit order.
// Combinational helpers only; no state, no latency, no flow control.
package s298_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FLUSH = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int LFSR_W     = 8;
    localparam int MISR_W     = 16;
    localparam int CORE_OUT_W = 6;

    // Feedback taps: LFSR bits 7,5,4,3; MISR bits 15,13,12,10.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b1011_1000;
    localparam logic [MISR_W-1:0] MISR_TAPS = 16'b1011_0100_0000_0000;

    // CORE_OUT bit positions: {G133,G132,G118,G117,G67,G66}.
    localparam int CO_G66  = 0;
    localparam int CO_G67  = 1;
    localparam int CO_G117 = 2;
    localparam int CO_G118 = 3;
    localparam int CO_G132 = 4;
    localparam int CO_G133 = 5;

    // Fibonacci shift-left: feedback XOR enters at bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
        return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
    endfunction

    function automatic logic [MISR_W-1:0] misr_next(input logic [MISR_W-1:0]     m,
                                                    input logic [CORE_OUT_W-1:0] d);
        return {m[MISR_W-2:0], ^(m & MISR_TAPS)} ^ {{(MISR_W-CORE_OUT_W){1'b0}}, d};
    endfunction

endpackage

// File: rtl/s298_misr16.sv
// 16-bit multiple-input signature register compacting the six s298 outputs.
// Latency: one cycle per update; sig reflects all updates through the previous edge.
// Backpressure: none; clr wins over en, en gates the compaction step.
//
// Ports: clk, rst_n (async active-low), clr (load zero), en (compact dat), dat[5:0], sig[15:0].
module s298_misr16
    import s298_bist_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  en,
    input  logic [CORE_OUT_W-1:0] dat,
    output logic [MISR_W-1:0]     sig
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= misr_next(sig, dat);
        end
    end

endmodule

// File: rtl/s298_bist_ctrl.sv
// BIST controller for one s298 core: flush, LFSR-driven stimulus, MISR compaction, golden compare.
// Latency: START accepted at edge e gives DONE in the cycle after edge e+FLUSH_CYCLES+N_PATTERNS+1... i.e. FLUSH_CYCLES+N_PATTERNS+1 cycles.
// Backpressure: none; START is only taken in IDLE (or DONE_ST, for back-to-back runs), otherwise dropped.
//
// Ports: CK, RSTN (async active-low), START, CORE_OUT[5:0] in; CORE_G0/1/2, BUSY, DONE, PASS out;
// SIGNATURE[15:0] out only when S298_BIST_SIG_OUT_EN is defined (golden-value extraction).
module s298_bist_ctrl
    import s298_bist_pkg::*;
#(
    parameter int                N_PATTERNS   = 256,
    parameter int                FLUSH_CYCLES = 16,
    parameter logic [LFSR_W-1:0] LFSR_SEED    = 8'h01,
    parameter logic [MISR_W-1:0] MISR_GOLDEN  = 16'h0000
)
(
    input  logic                  CK,
    input  logic                  RSTN,
    input  logic                  START,
    input  logic [CORE_OUT_W-1:0] CORE_OUT,
    output logic                  CORE_G0,
    output logic                  CORE_G1,
    output logic                  CORE_G2,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  PASS
`ifdef S298_BIST_SIG_OUT_EN
    ,
    output logic [MISR_W-1:0]     SIGNATURE
`endif
);

    localparam int CNT_MAX = (N_PATTERNS > FLUSH_CYCLES) ? N_PATTERNS : FLUSH_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(N_PATTERNS - 1);

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                accept;
    logic [LFSR_W-1:0]   lfsr;
    logic [MISR_W-1:0]   sig;
    logic                sig_match;
    logic                pass_q;

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (START) begin
                    accept    = 1'b1;
                    state_nxt = ST_FLUSH;
                    cnt_nxt   = '0;
                end
            end
            ST_FLUSH: begin
                if (cnt == FLUSH_LAST) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (cnt == RUN_LAST) begin
                    state_nxt = ST_DRAIN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                // A START still held here re-arms without an IDLE bubble, so
                // back-to-back DONE pulses sit FLUSH_CYCLES+N_PATTERNS+2 apart.
                if (START) begin
                    accept    = 1'b1;
                    state_nxt = ST_FLUSH;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Stimulus LFSR: reloaded on accept, steps once per RUN cycle so the
    // value presented in RUN cycle k is the k-th pattern after the seed.
    // ---------------------------------------------------------------
    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            lfsr <= LFSR_SEED;
        end else if (accept) begin
            lfsr <= LFSR_SEED;
        end else if (state == ST_RUN) begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    // ---------------------------------------------------------------
    // Response compaction: RUN edges plus the DRAIN edge, which catches the
    // core's registered reaction to the final pattern.
    // ---------------------------------------------------------------
    s298_misr16 u_misr (
        .clk   (CK),
        .rst_n (RSTN),
        .clr   (accept),
        .en    ((state == ST_RUN) || (state == ST_DRAIN)),
        .dat   (CORE_OUT),
        .sig   (sig)
    );

    assign sig_match = (sig == MISR_GOLDEN);

    // The MISR is final during DONE_ST, so PASS there comes straight from the
    // compare; pass_q captures it on leaving DONE_ST and holds until the next
    // accepted START clears it.
    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            pass_q <= 1'b0;
        end else if (accept) begin
            pass_q <= 1'b0;
        end else if (state == ST_DONE) begin
            pass_q <= sig_match;
        end
    end

    // ---------------------------------------------------------------
    // Outputs: decoded from state and registered LFSR/MISR/pass only.
    // ---------------------------------------------------------------
    assign CORE_G0 = (state == ST_FLUSH) || ((state == ST_RUN) && lfsr[0]);
    assign CORE_G1 = (state == ST_RUN) && lfsr[1];
    assign CORE_G2 = (state == ST_RUN) && lfsr[2];
    assign BUSY    = (state == ST_FLUSH) || (state == ST_RUN) || (state == ST_DRAIN);
    assign DONE    = (state == ST_DONE);
    assign PASS    = (state == ST_DONE) ? sig_match : pass_q;

`ifdef S298_BIST_SIG_OUT_EN
    assign SIGNATURE = sig;
`endif

endmodule

// File: tb/tb_s298_bist_ctrl.sv
// Self-checking bench for s298_bist_ctrl with FLUSH_CYCLES=2, N_PATTERNS=4, seed 8'h01.
// Three instances share stimulus and differ only in MISR_GOLDEN (0, 1, 1F).
// Honors S298_BIST_SIG_OUT_EN to connect and check SIGNATURE.
module tb_s298_bist_ctrl;

    localparam int F = 2;
    localparam int N = 4;

    logic        CK = 1'b0;
    logic        RSTN;
    logic        START;
    logic [5:0]  CORE_OUT;
    logic [2:0]  cg0, cg1, cg2, busy, done, pass;
`ifdef S298_BIST_SIG_OUT_EN
    logic [15:0] sig0, sig1, sig2;
`endif

    int errors = 0;
    int checks = 0;

    always #5 CK = ~CK;

    s298_bist_ctrl #(.N_PATTERNS(N), .FLUSH_CYCLES(F), .LFSR_SEED(8'h01), .MISR_GOLDEN(16'h0000)) u0 (
        .CK(CK), .RSTN(RSTN), .START(START), .CORE_OUT(CORE_OUT),
        .CORE_G0(cg0[0]), .CORE_G1(cg1[0]), .CORE_G2(cg2[0]),
        .BUSY(busy[0]), .DONE(done[0]), .PASS(pass[0])
`ifdef S298_BIST_SIG_OUT_EN
        , .SIGNATURE(sig0)
`endif
    );

    s298_bist_ctrl #(.N_PATTERNS(N), .FLUSH_CYCLES(F), .LFSR_SEED(8'h01), .MISR_GOLDEN(16'h0001)) u1 (
        .CK(CK), .RSTN(RSTN), .START(START), .CORE_OUT(CORE_OUT),
        .CORE_G0(cg0[1]), .CORE_G1(cg1[1]), .CORE_G2(cg2[1]),
        .BUSY(busy[1]), .DONE(done[1]), .PASS(pass[1])
`ifdef S298_BIST_SIG_OUT_EN
        , .SIGNATURE(sig1)
`endif
    );

    s298_bist_ctrl #(.N_PATTERNS(N), .FLUSH_CYCLES(F), .LFSR_SEED(8'h01), .MISR_GOLDEN(16'h001F)) u2 (
        .CK(CK), .RSTN(RSTN), .START(START), .CORE_OUT(CORE_OUT),
        .CORE_G0(cg0[2]), .CORE_G1(cg1[2]), .CORE_G2(cg2[2]),
        .BUSY(busy[2]), .DONE(done[2]), .PASS(pass[2])
`ifdef S298_BIST_SIG_OUT_EN
        , .SIGNATURE(sig2)
`endif
    );

    // One row per edge: START applied before edge i, outputs expected after it.
    typedef struct {
        logic       start;
        logic [2:0] g;        // {G2,G1,G0}
        logic       busy;
        logic       done;
        logic       pass_on;  // PASS shows the run's verdict (else 0)
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #2;
    endtask

    task automatic run_table(input logic [5:0] co, input logic [2:0] exp_pass,
                             input logic [15:0] exp_sig);
        CORE_OUT = co;
        for (int i = 0; i < 9; i++) begin
            START = tbl[i].start;
            tick();
            chk($sformatf("tbl%0d_g", i),    {29'd0, cg2[0], cg1[0], cg0[0]}, {29'd0, tbl[i].g});
            chk($sformatf("tbl%0d_busy", i), {31'd0, busy[0]}, {31'd0, tbl[i].busy});
            chk($sformatf("tbl%0d_done", i), {31'd0, done[0]}, {31'd0, tbl[i].done});
            chk($sformatf("tbl%0d_pass", i), {29'd0, pass},
                tbl[i].pass_on ? {29'd0, exp_pass} : 32'd0);
`ifdef S298_BIST_SIG_OUT_EN
            if (i == 7) chk("tbl_sig", {16'd0, sig2}, {16'd0, exp_sig});
`else
            if (i == 7 && exp_sig == 16'hFFFF) chk("tbl_sig_unused", 32'd0, 32'd1);
`endif
        end
        START = 1'b0;
    endtask

    initial begin
        int ndone;

        tbl[0] = '{1'b1, 3'b001, 1'b1, 1'b0, 1'b0};  // FLUSH
        tbl[1] = '{1'b0, 3'b001, 1'b1, 1'b0, 1'b0};  // FLUSH
        tbl[2] = '{1'b0, 3'b001, 1'b1, 1'b0, 1'b0};  // RUN, LFSR=01
        tbl[3] = '{1'b0, 3'b010, 1'b1, 1'b0, 1'b0};  // RUN, LFSR=02
        tbl[4] = '{1'b0, 3'b100, 1'b1, 1'b0, 1'b0};  // RUN, LFSR=04
        tbl[5] = '{1'b0, 3'b000, 1'b1, 1'b0, 1'b0};  // RUN, LFSR=08
        tbl[6] = '{1'b0, 3'b000, 1'b1, 1'b0, 1'b0};  // DRAIN
        tbl[7] = '{1'b0, 3'b000, 1'b0, 1'b1, 1'b1};  // DONE_ST
        tbl[8] = '{1'b0, 3'b000, 1'b0, 1'b0, 1'b1};  // IDLE, PASS held

        // Reset state
        RSTN = 1'b0; START = 1'b0; CORE_OUT = 6'h00;
        #12;
        chk("rst_g",    {29'd0, cg2[0], cg1[0], cg0[0]}, 32'd0);
        chk("rst_busy", {29'd0, busy}, 32'd0);
        chk("rst_done", {29'd0, done}, 32'd0);
        chk("rst_pass", {29'd0, pass}, 32'd0);
`ifdef S298_BIST_SIG_OUT_EN
        chk("rst_sig",  {16'd0, sig0}, 32'd0);
`endif
        @(negedge CK);
        RSTN = 1'b1;

        // Core outputs stubbed to 0: signature 0, only golden 0 passes.
        run_table(6'h00, 3'b001, 16'h0000);
        // Core outputs held at 01: five updates give 001F.
        run_table(6'h01, 3'b100, 16'h001F);

        // START pulsed during RUN is ignored.
        CORE_OUT = 6'h01;
        ndone = 0;
        for (int k = 0; k < 13; k++) begin
            START = (k == 0 || k == 4);
            tick();
            chk($sformatf("ign%0d_done", k), {31'd0, done[0]}, {31'd0, (k == 7)});
            if (done[0]) ndone++;
            if (k == 7) chk("ign_pass", {29'd0, pass}, 32'd4);
        end
        START = 1'b0;
        chk("ign_done_count", ndone, 1);

        // Reset in cycle 4 (RUN) aborts immediately; PASS from the prior run cleared.
        for (int k = 0; k < 4; k++) begin
            START = (k == 0);
            tick();
        end
        START = 1'b0;
        chk("abort_pre_g", {29'd0, cg2[0], cg1[0], cg0[0]}, 32'd2);
        RSTN = 1'b0;
        #1;
        chk("abort_busy", {29'd0, busy}, 32'd0);
        chk("abort_g",    {29'd0, cg2, cg1, cg0} & 32'h1FF, 32'd0);
        chk("abort_pass", {29'd0, pass}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("abort%0d_done", k), {29'd0, done}, 32'd0);
        end
        @(negedge CK);
        RSTN = 1'b1;
        run_table(6'h01, 3'b100, 16'h001F);

        // START held high: back-to-back runs, DONE every F+N+2 cycles.
        for (int k = 0; k < 25; k++) begin
            START = 1'b1;
            tick();
            chk($sformatf("b2b%0d_done", k), {31'd0, done[0]},
                {31'd0, (k == 7 || k == 15 || k == 23)});
            if (k == 7 || k == 15) chk($sformatf("b2b%0d_pass", k), {31'd0, pass[2]}, 32'd1);
            if (k == 8 || k == 16) begin
                chk($sformatf("b2b%0d_passclr", k), {31'd0, pass[2]}, 32'd0);
                chk($sformatf("b2b%0d_busy", k), {31'd0, busy[0]}, 32'd1);
            end
        end
        START = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
